// File: rtl/ramb4_s4_reader_if.sv
// Command, RAMB4_S4 read port and nibble stream of the burst reader.
// master = reader side, slave = environment (command source, RAM, stream sink).
interface ramb4_s4_reader_if #(
  parameter int AW = 10,
  parameter int DW = 4
);
  logic          START;
  logic [AW-1:0] START_ADDR;
  logic [AW:0]   LEN;
  logic          BUSY;
  logic          DONE;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_EN;
  logic          RAM_WE;
  logic          RAM_RST;
  logic [DW-1:0] RAM_DO;
  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic          M_LAST;

  modport master (
    input  START, START_ADDR, LEN, RAM_DO, M_READY,
    output BUSY, DONE, RAM_ADDR, RAM_EN, RAM_WE, RAM_RST, M_DATA, M_VALID, M_LAST
  );

  modport slave (
    output START, START_ADDR, LEN, RAM_DO, M_READY,
    input  BUSY, DONE, RAM_ADDR, RAM_EN, RAM_WE, RAM_RST, M_DATA, M_VALID, M_LAST
  );
endinterface

// File: rtl/ramb4_s4_reader.sv
// Streams LEN nibbles from a RAMB4_S4 starting at START_ADDR; first data 2 cycles after START.
// Backpressure via M_READY; reads are throttled so FIFO entries plus the in-flight read never exceed 2.
module ramb4_s4_reader #(
  parameter int AW = 10,
  parameter int DW = 4
) (
  input  logic             CLK,
  input  logic             RST,
  ramb4_s4_reader_if.master bus
);
  localparam logic [AW:0] MAX_LEN = (AW+1)'(1) << AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [AW:0]   remaining;
  logic [AW-1:0] addr;
  logic          in_flight;
  logic          in_flight_last;
  logic          done;
  logic [DW-1:0] fifo_dat [2];
  logic [1:0]    fifo_last;
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    occ;

  logic          m_valid;
  logic          pop;
  logic          ram_en;
  logic [2:0]    pending;
  logic [AW:0]   len_clamped;

  assign len_clamped = (bus.LEN > MAX_LEN) ? MAX_LEN : bus.LEN;
  assign m_valid     = (occ != 2'd0);
  assign pop         = m_valid & bus.M_READY;
  // Slots committed after this edge: buffered + returning read - the one leaving now.
  assign pending     = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};
  assign ram_en      = (state == RUN) && (remaining != '0) && (pending < 3'd2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      remaining      <= '0;
      addr           <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      done           <= 1'b0;
      fifo_dat[0]    <= '0;
      fifo_dat[1]    <= '0;
      fifo_last      <= '0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      occ            <= '0;
    end else begin
      done           <= 1'b0;
      in_flight      <= ram_en;
      in_flight_last <= (remaining == (AW+1)'(1));

      if (ram_en) begin
        remaining <= remaining - (AW+1)'(1);
        addr      <= addr + AW'(1);
      end

      if (in_flight) begin
        fifo_dat[wr_ptr]  <= bus.RAM_DO;
        fifo_last[wr_ptr] <= in_flight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, in_flight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (bus.START) begin
            if (len_clamped == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              remaining <= len_clamped;
              addr      <= bus.START_ADDR;
            end
          end
        end
        RUN: begin
          if (ram_en && remaining == (AW+1)'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_last[rd_ptr]) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY     = (state != IDLE);
  assign bus.DONE     = done;
  assign bus.RAM_ADDR = addr;
  assign bus.RAM_EN   = ram_en;
  assign bus.RAM_WE   = 1'b0;
  assign bus.RAM_RST  = 1'b0;
  assign bus.M_VALID  = m_valid;
  assign bus.M_DATA   = fifo_dat[rd_ptr];
  assign bus.M_LAST   = m_valid & fifo_last[rd_ptr];
endmodule

// File: doc/ramb4_s4_reader.md
RAMB4_S4_READER -- requirements
Module: ramb4_s4_reader

Interface
REQ-001 SHALL have parameters: AW, 10, RAM address width; DW, 4, RAM data width.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port START  input  1  one-cycle command strobe, sampled only while BUSY=0.
REQ-005 SHALL have port START_ADDR  input  AW  first RAM address of the burst.
REQ-006 SHALL have port LEN  input  AW+1  nibble count; 0 = empty burst, values >1024 clamp to 1024.
REQ-007 SHALL have port BUSY  output  1  burst in progress.
REQ-008 SHALL have port DONE  output  1  one-cycle pulse at burst completion.
REQ-009 SHALL have port RAM_ADDR  output  AW  address to RAMB4_S4 ADDR.
REQ-010 SHALL have port RAM_EN  output  1  read enable to RAMB4_S4 EN.
REQ-011 SHALL have port RAM_WE  output  1  tied 0.
REQ-012 SHALL have port RAM_RST  output  1  tied 0.
REQ-013 SHALL have port RAM_DO  input  DW  RAMB4_S4 DO, valid after the edge sampling RAM_EN=1.
REQ-014 SHALL have port M_DATA  output  DW  stream data.
REQ-015 SHALL have port M_VALID  output  1  stream data valid.
REQ-016 SHALL have port M_READY  input  1  downstream accept.
REQ-017 SHALL have port M_LAST  output  1  marks final nibble of burst, qualified by M_VALID.

Function
REQ-018 SHALL implement FSM IDLE -> RUN on START (LEN>0); RUN -> DRAIN when last read issued; DRAIN -> IDLE on handshake of M_LAST; IDLE -> IDLE with DONE pulse on START with LEN=0.
REQ-019 SHALL latch START_ADDR and clamped LEN on the START edge; later changes to these inputs have no effect until the next START.
REQ-020 SHALL ignore START while BUSY=1.
REQ-021 SHALL hold BUSY=1 from the cycle after accepted START (LEN>0) until the DONE cycle, where BUSY=0.
REQ-022 SHALL issue reads in ascending address order, RAM_ADDR wrapping 0x3FF -> 0x000.
REQ-023 SHALL buffer read data in a 2-entry FIFO; one read may be in flight.
REQ-024 SHALL assert RAM_EN only in RUN with reads remaining and (occupancy + in_flight - pop) < 2, pop = M_VALID & M_READY (RAM_EN may depend combinationally on M_READY).
REQ-025 SHALL capture RAM_DO into the FIFO only on the edge following an issued read.
REQ-026 SHALL give first-data latency of 2 cycles: START sampled at edge k -> RAM_EN=1 in cycle k+1 -> M_VALID=1 after edge k+2.
REQ-027 SHALL sustain one nibble per cycle while M_READY=1.
REQ-028 SHALL hold M_DATA, M_LAST stable while M_VALID=1 and M_READY=0; no nibble lost or duplicated.
REQ-029 SHALL assert M_LAST only with the LEN-th nibble.
REQ-030 SHALL pulse DONE for one cycle, the cycle after M_LAST handshake or after START with LEN=0.
REQ-031 SHALL never write the RAM (RAM_WE=0, RAM_RST=0 at all times).

Reset
REQ-032 SHALL, while RST=0, immediately force: state IDLE, BUSY=0, DONE=0, RAM_EN=0, RAM_ADDR=0, M_VALID=0, M_LAST=0, M_DATA=0, FIFO empty, in_flight=0.
REQ-033 SHALL discard any burst and in-flight read on reset mid-operation; no residual data after RST rises.
REQ-034 SHALL accept a START in the first cycle after RST rises.

Verification
REQ-035 SHALL cover: RST=0 at any time -> all outputs 0 within the same cycle, RAM_WE=RAM_RST=0.
REQ-036 SHALL cover: RAM[0x010..0x013]=1,2,3,4, START_ADDR=0x010, LEN=4, M_READY=1 -> M_DATA 1,2,3,4 on consecutive cycles from k+3, M_LAST with 4, DONE next cycle.
REQ-037 SHALL cover: START_ADDR=0x3FE, LEN=4 -> RAM_ADDR sequence 0x3FE,0x3FF,0x000,0x001.
REQ-038 SHALL cover: LEN=16, M_READY random 50% -> 16 nibbles in order, stable under stall, RAM_EN never raises occupancy+in_flight above 2.
REQ-039 SHALL cover: LEN=0 -> DONE one cycle after START, no RAM_EN; START during BUSY -> ignored, burst unchanged.
REQ-040 SHALL cover: RST low after 3 of 8 nibbles -> outputs cleared; new burst LEN=2 after release -> exactly 2 correct nibbles, M_LAST on second.
